// File: rtl/ahb_slave_if.sv
// AHB-Lite responder front-end: decodes and range-checks address-phase control and inserts wait
// states. Each accepted transfer becomes one req/ack handshake towards user-side logic.
module ahb_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] ADDR_RANGE = 32'h0000_1000,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_hsel,
  input  logic [ADDR_WIDTH-1:0] i_haddr,
  input  logic [1:0]            i_htrans,
  input  logic                  i_hwrite,
  input  logic [2:0]            i_hsize,
  input  logic [2:0]            i_hburst,
  input  logic [DATA_WIDTH-1:0] i_hwdata,
  input  logic                  i_hready,
  output logic                  o_hreadyout,
  output logic                  o_hresp,
  output logic [DATA_WIDTH-1:0] o_hrdata,
  output logic                  o_usr_req,
  output logic                  o_usr_write,
  output logic [2:0]            o_usr_burst_type,
  output logic [2:0]            o_usr_size,
  output logic [ADDR_WIDTH-1:0] o_usr_addr,
  output logic [DATA_WIDTH-1:0] o_usr_wdata,
  input  logic                  i_usr_ack,
  input  logic [DATA_WIDTH-1:0] i_usr_rdata,
  output logic                  o_busy
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWrData = 3'd1;
  localparam logic [2:0] StWrReq  = 3'd2;
  localparam logic [2:0] StRdReq  = 3'd3;
  localparam logic [2:0] StErr1   = 3'd4;
  localparam logic [2:0] StErr2   = 3'd5;

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT - 1);
  localparam bit TmoEn = (TIMEOUT != 0);

  logic [2:0]            state_q, state_d;
  logic                  hreadyout_q, hreadyout_d;
  logic                  hresp_q, hresp_d;
  logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;
  logic                  usr_req_q, usr_req_d;
  logic                  usr_write_q, usr_write_d;
  logic [2:0]            usr_burst_q, usr_burst_d;
  logic [2:0]            usr_size_q, usr_size_d;
  logic [ADDR_WIDTH-1:0] usr_addr_q, usr_addr_d;
  logic [DATA_WIDTH-1:0] usr_wdata_q, usr_wdata_d;
  logic [CntW-1:0]       tmo_cnt_q, tmo_cnt_d;

  logic                  accept;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  in_window;
  logic                  misaligned;
  logic                  addr_err;
  logic                  tmo_hit;

  // ERR2 drives HREADYOUT high, so a pipelined address phase may be taken there as from IDLE.
  assign accept = i_hsel & i_htrans[1] & i_hready &
                  ((state_q == StIdle) | (state_q == StErr2));

  // Offset comparison avoids overflow when BASE_ADDR + ADDR_RANGE wraps the address space.
  assign offset    = i_haddr - BASE_ADDR;
  assign in_window = (i_haddr >= BASE_ADDR) & (offset < ADDR_RANGE);

  always_comb begin
    misaligned = 1'b0;
    case (i_hsize)
      3'b001:  misaligned = i_haddr[0];
      3'b010:  misaligned = |i_haddr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign addr_err = (i_hsize > 3'b010) | ~in_window | misaligned;
  assign tmo_hit  = TmoEn && (tmo_cnt_q == TmoLast);

  always_comb begin
    state_d     = state_q;
    hreadyout_d = hreadyout_q;
    hresp_d     = hresp_q;
    hrdata_d    = hrdata_q;
    usr_req_d   = usr_req_q;
    usr_write_d = usr_write_q;
    usr_burst_d = usr_burst_q;
    usr_size_d  = usr_size_q;
    usr_addr_d  = usr_addr_q;
    usr_wdata_d = usr_wdata_q;
    tmo_cnt_d   = tmo_cnt_q;

    case (state_q)
      StIdle, StErr2: begin
        state_d     = StIdle;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
        if (accept) begin
          if (addr_err) begin
            // Range/size errors never reach the user side.
            state_d     = StErr1;
            hreadyout_d = 1'b0;
            hresp_d     = 1'b1;
          end else begin
            usr_addr_d  = offset;
            usr_size_d  = i_hsize;
            usr_burst_d = i_hburst;
            usr_write_d = i_hwrite;
            hreadyout_d = 1'b0;
            tmo_cnt_d   = '0;
            if (i_hwrite) begin
              state_d = StWrData;
            end else begin
              state_d   = StRdReq;
              usr_req_d = 1'b1;
            end
          end
        end
      end

      StWrData: begin
        usr_wdata_d = i_hwdata;
        usr_req_d   = 1'b1;
        tmo_cnt_d   = '0;
        state_d     = StWrReq;
      end

      StWrReq, StRdReq: begin
        // Ack wins over a timeout expiring in the same cycle.
        if (i_usr_ack) begin
          usr_req_d   = 1'b0;
          hreadyout_d = 1'b1;
          state_d     = StIdle;
          if (state_q == StRdReq) begin
            hrdata_d = i_usr_rdata;
          end
        end else if (tmo_hit) begin
          usr_req_d = 1'b0;
          hresp_d   = 1'b1;
          state_d   = StErr1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      StErr1: begin
        hreadyout_d = 1'b1;
        hresp_d     = 1'b1;
        state_d     = StErr2;
      end

      default: begin
        state_d     = StIdle;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
        usr_req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
      usr_req_q   <= 1'b0;
      usr_write_q <= 1'b0;
      usr_burst_q <= '0;
      usr_size_q  <= '0;
      usr_addr_q  <= '0;
      usr_wdata_q <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      usr_req_q   <= usr_req_d;
      usr_write_q <= usr_write_d;
      usr_burst_q <= usr_burst_d;
      usr_size_q  <= usr_size_d;
      usr_addr_q  <= usr_addr_d;
      usr_wdata_q <= usr_wdata_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign o_hreadyout      = hreadyout_q;
  assign o_hresp          = hresp_q;
  assign o_hrdata         = hrdata_q;
  assign o_usr_req        = usr_req_q;
  assign o_usr_write      = usr_write_q;
  assign o_usr_burst_type = usr_burst_q;
  assign o_usr_size       = usr_size_q;
  assign o_usr_addr       = usr_addr_q;
  assign o_usr_wdata      = usr_wdata_q;
  assign o_busy           = (state_q != StIdle);

endmodule
